// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file with two bypassed read ports and a reset-time clear sequencer
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic        re1,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic        re2,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2,
  output logic        stallreq_init
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [4:0]  icnt;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] regs [0:31];

  // Single write port shared between the clear sequencer and the write-back path.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = waddr;
    mem_data = wdata;
    if (!rst) begin
      if (state == INIT) begin
        mem_we   = 1'b1;
        mem_addr = icnt;
        mem_data = 32'h0000_0000;
      end else if (we && (waddr != 5'd0)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      icnt  <= 5'd1;
    end else if (state == INIT) begin
      icnt <= icnt + 5'd1;
      if (icnt == 5'd31) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      regs[mem_addr] <= mem_data;
    end
  end

  function automatic logic [31:0] read_port(input logic re, input logic [4:0] raddr);
    if (rst || (state == INIT)) begin
      return 32'h0000_0000;
    end else if (!re) begin
      return 32'h0000_0000;
    end else if (raddr == 5'd0) begin
      return 32'h0000_0000;
    end else if (we && (waddr == raddr)) begin
      return wdata;
    end else begin
      return regs[raddr];
    end
  endfunction

  always_comb begin
    rdata1 = read_port(re1, raddr1);
    rdata2 = read_port(re2, raddr2);
  end

  assign stallreq_init = rst || (state == INIT);

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized and directed check of regfile against a behavioural model
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        stallreq_init;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: architectural register values plus number of clear cycles still owed.
  logic [31:0] model [0:31];
  int          init_left = 31;

  regfile dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .re1(re1),
    .raddr1(raddr1),
    .rdata1(rdata1),
    .re2(re2),
    .raddr2(raddr2),
    .rdata2(rdata2),
    .stallreq_init(stallreq_init)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expect_read(input logic r, input logic [4:0] a);
    if (rst || init_left > 0) return 32'h0;
    if (!r) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return model[a];
  endfunction

  // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag,
                      input logic s_rst, input logic s_we, input logic [4:0] s_waddr,
                      input logic [31:0] s_wdata,
                      input logic s_re1, input logic [4:0] s_raddr1,
                      input logic s_re2, input logic [4:0] s_raddr2);
    rst = s_rst; we = s_we; waddr = s_waddr; wdata = s_wdata;
    re1 = s_re1; raddr1 = s_raddr1; re2 = s_re2; raddr2 = s_raddr2;
    @(negedge clk);
    check({tag, ".stall"}, {31'b0, stallreq_init}, {31'b0, (s_rst || init_left > 0)});
    check({tag, ".rdata1"}, rdata1, expect_read(s_re1, s_raddr1));
    check({tag, ".rdata2"}, rdata2, expect_read(s_re2, s_raddr2));
    @(posedge clk);
    if (s_rst) begin
      init_left = 31;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end
    end else if (s_we && s_waddr != 5'd0) begin
      model[s_waddr] = s_wdata;
    end
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    for (int i = 0; i < 3; i++)
      step("reset", 1'b1, 1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4, 1'b1, 5'd1);
    // First INIT cycle, then a write at INIT cycle 2 that must be dropped.
    step("init1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd1);
    step("init_we", 1'b0, 1'b1, 5'd3, 32'hAAAA_AAAA, 1'b1, 5'd3, 1'b1, 5'd3);
    for (int i = 0; i < 29; i++)
      step("init", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i + 1), 1'b1, 5'd31);
    check("init_done.stall", {31'b0, stallreq_init}, 32'd0);
    for (int a = 1; a < 32; a++)
      step("clear", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(32 - a));

    step("wr_r5", 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd_r5", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("r5_direct", rdata1, 32'hDEAD_BEEF);
    step("rd_r5_off", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5);

    step("wr_r0", 1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b1, 5'd0, 1'b1, 5'd0);
    step("rd_r0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);

    step("wr_r7", 1'b0, 1'b1, 5'd7, 32'h1111_1111, 1'b0, 5'd0, 1'b0, 5'd0);
    step("byp_r7", 1'b0, 1'b1, 5'd7, 32'h2222_2222, 1'b1, 5'd7, 1'b1, 5'd7);
    step("post_r7", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
    check("r7_direct", rdata2, 32'h2222_2222);

    step("wr_r9", 1'b0, 1'b1, 5'd9, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0);
    step("rd_r9", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    step("mid_rst", 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    for (int i = 0; i < 31; i++) idle("reinit");
    step("r9_clear", 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd5);

    for (int c = 0; c < 3000; c++) begin
      logic        r_rst, r_we, r_re1, r_re2;
      logic [4:0]  r_wa, r_a1, r_a2;
      logic [4:0]  hot [0:3];
      hot[0] = 5'd0; hot[1] = 5'd1; hot[2] = 5'd7; hot[3] = 5'd31;
      r_rst = ($urandom_range(0, 299) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_wa  = ($urandom_range(0, 1) == 1) ? hot[$urandom_range(0, 3)] : 5'($urandom);
      r_a1  = ($urandom_range(0, 2) == 0) ? r_wa : 5'($urandom);
      r_a2  = ($urandom_range(0, 2) == 0) ? r_wa : hot[$urandom_range(0, 3)];
      r_re1 = $urandom_range(0, 4) != 0;
      r_re2 = $urandom_range(0, 4) != 0;
      step("rand", r_rst, r_we, r_wa, $urandom, r_re1, r_a1, r_re2, r_a2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
